tx_rd_req_tlp_gen: RTL

TX_RD_REQ_TLP_GEN -- requirements
Module: tx_rd_req_tlp_gen

---
 rtl/tx_rd_req_tlp_gen_pkg.sv | 22 ++
 rtl/tx_rd_req_tlp_gen_hdr_build.sv | 29 ++
 rtl/tx_rd_req_tlp_gen.sv | 129 ++++++++++++
 3 files changed

// File: rtl/tx_rd_req_tlp_gen_pkg.sv
// Shared constants and FSM encoding for the 512-byte memory-read request generator.
package tx_rd_req_tlp_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARB  = 3'd1,
    ST_HDR0 = 3'd2,
    ST_HDR1 = 3'd3,
    ST_WAIT = 3'd4
  } state_e;

  // {fmt[1:0], type[4:0]} for 4DW and 3DW memory reads
  localparam logic [6:0] FMT_TYPE_MRD64 = 7'b01_00000;
  localparam logic [6:0] FMT_TYPE_MRD32 = 7'b00_00000;

  localparam logic [9:0] CHUNK_LEN_DW = 10'h080;
  localparam logic [3:0] BE_ALL       = 4'hF;

  localparam logic [7:0] TREM_N_BOTH_DW  = 8'h00;
  localparam logic [7:0] TREM_N_UPPER_DW = 8'h0F;

endpackage

// File: rtl/tx_rd_req_tlp_gen_hdr_build.sv
// Combinational MemRd header assembly: two 64-bit TRN beats from address, tag and requester ID.
module tlp_mrd_hdr_build
  import tx_rd_req_tlp_gen_pkg::*;
(
  input  logic [63:0] addr_i,
  input  logic [4:0]  tag_i,
  input  logic [15:0] req_id_i,
  input  logic        mrd32_i,
  output logic [63:0] beat0_o,
  output logic [63:0] beat1_o,
  output logic [7:0]  beat1_trem_n_o
);

  logic [6:0]  fmt_type;
  logic [31:0] dw0;
  logic [31:0] dw1;
  logic [31:0] addr_lo;

  assign fmt_type = mrd32_i ? FMT_TYPE_MRD32 : FMT_TYPE_MRD64;
  // R, fmt/type, R, TC, R, TD, EP, attr, R, length
  assign dw0      = {1'b0, fmt_type, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, CHUNK_LEN_DW};
  assign dw1      = {req_id_i, 3'b000, tag_i, BE_ALL, BE_ALL};
  assign addr_lo  = addr_i[31:0] & 32'hFFFF_FFFC;

  assign beat0_o        = {dw0, dw1};
  assign beat1_o        = mrd32_i ? {addr_lo, 32'h0000_0000} : {addr_i[63:32], addr_lo};
  assign beat1_trem_n_o = mrd32_i ? TREM_N_UPPER_DW : TREM_N_BOTH_DW;

endmodule

// File: rtl/tx_rd_req_tlp_gen.sv
// Issues one 512-byte MemRd TLP per read_chunk request on the TRN TX interface.
// Optional MRD32_FALLBACK_EN: addresses below 4 GiB go out as 3DW MemRd32.
module tx_rd_req_tlp_gen
  import tx_rd_req_tlp_gen_pkg::*;
(
  input  logic        trn_clk,
  input  logic        reset_n,
  input  logic        read_chunk,
  input  logic [63:0] huge_page_addr_read_from,
  output logic        read_chunk_ack,
  input  logic [15:0] cfg_completer_id,
  output logic        tx_arb_req,
  input  logic        tx_arb_gnt,
  output logic [63:0] trn_td,
  output logic [7:0]  trn_trem_n,
  output logic        trn_tsof_n,
  output logic        trn_teof_n,
  output logic        trn_tsrc_rdy_n,
  output logic        trn_tsrc_dsc_n,
  input  logic        trn_tdst_rdy_n,
  input  logic [5:0]  trn_tbuf_av
);

  state_e      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [4:0]  tag_q, tag_d;
  logic        ack_q, ack_d;
  logic        start;
  logic        use_mrd32;
  logic [63:0] beat0;
  logic [63:0] beat1;
  logic [7:0]  beat1_trem_n;

  // The address must be captured on the very first cycle of read_chunk.
  assign start = (state_q == ST_IDLE) && read_chunk && (trn_tbuf_av != 6'd0);

`ifdef MRD32_FALLBACK_EN
  logic mrd32_q;

  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n)   mrd32_q <= 1'b0;
    else if (start) mrd32_q <= (huge_page_addr_read_from[63:32] == 32'h0);
  end

  assign use_mrd32 = mrd32_q;
`else
  assign use_mrd32 = 1'b0;
`endif

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tag_d   = tag_q;
    ack_d   = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        addr_d  = huge_page_addr_read_from;
        state_d = ST_ARB;
      end
      ST_ARB:  if (tx_arb_gnt) state_d = ST_HDR0;
      ST_HDR0: if (!trn_tdst_rdy_n) state_d = ST_HDR1;
      ST_HDR1: if (!trn_tdst_rdy_n) begin
        ack_d   = 1'b1;
        tag_d   = tag_q + 5'd1;
        state_d = ST_WAIT;
      end
      ST_WAIT: if (!read_chunk) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      tag_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tag_q   <= tag_d;
      ack_q   <= ack_d;
    end
  end

  // tag_q only advances after EOF is accepted, so it already holds the latched tag for the whole TLP.
  tlp_mrd_hdr_build u_hdr (
    .addr_i         (addr_q),
    .tag_i          (tag_q),
    .req_id_i       (cfg_completer_id),
    .mrd32_i        (use_mrd32),
    .beat0_o        (beat0),
    .beat1_o        (beat1),
    .beat1_trem_n_o (beat1_trem_n)
  );

  // Outputs decode straight from the state register, so reset idles them asynchronously.
  always_comb begin
    tx_arb_req     = 1'b0;
    trn_tsof_n     = 1'b1;
    trn_teof_n     = 1'b1;
    trn_tsrc_rdy_n = 1'b1;
    trn_trem_n     = TREM_N_BOTH_DW;
    trn_td         = '0;
    case (state_q)
      ST_ARB:  tx_arb_req = 1'b1;
      ST_HDR0: begin
        tx_arb_req     = 1'b1;
        trn_tsof_n     = 1'b0;
        trn_tsrc_rdy_n = 1'b0;
        trn_td         = beat0;
      end
      ST_HDR1: begin
        tx_arb_req     = 1'b1;
        trn_teof_n     = 1'b0;
        trn_tsrc_rdy_n = 1'b0;
        trn_trem_n     = beat1_trem_n;
        trn_td         = beat1;
      end
      default: ;
    endcase
  end

  assign read_chunk_ack = ack_q;
  assign trn_tsrc_dsc_n = 1'b1;

endmodule
